// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: symbol timing default, splitter FSM encoding and the
// scrambler LFSR seed/taps shared with the receive-side descrambler.
package qpsk_pkg;

  localparam int SAMPLE_DEF = 100;
  localparam int CNT_W_DEF  = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } out_state_e;

  // x^7 + x^4 + 1, shifting toward bit 6
  localparam logic [6:0] LFSR_SEED   = 7'h7F;
  localparam int         LFSR_TAP_HI = 6;
  localparam int         LFSR_TAP_LO = 3;

  function automatic logic [6:0] lfsr_next(input logic [6:0] s);
    return {s[5:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/qpsk_scrambler.sv
// Additive scrambler: XORs each accepted bit with the LFSR MSB, stepping the
// LFSR only when a bit is actually taken.
module qpsk_scrambler
  import qpsk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic bit_i,
  output logic bit_o
);

  logic [6:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  lfsr <= LFSR_SEED;
    else if (en) lfsr <= lfsr_next(lfsr);
  end

  assign bit_o = bit_i ^ lfsr[LFSR_TAP_HI];

endmodule

// File: rtl/iq_split.sv
// Serial-to-IQ splitter: pairs accepted bits (Q first, then I) and holds each
// symbol for SAMPLE clocks. Define IQ_SPLIT_SCRAMBLE_EN to scramble input bits.
module iq_split
  import qpsk_pkg::*;
#(
  parameter int SAMPLE = SAMPLE_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_i,
  input  logic bit_valid_i,
  output logic bit_ready_o,
  output logic sym_I_o,
  output logic sym_Q_o,
  output logic sym_valid_o,
  output logic sym_strobe_o,
  output logic underrun_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE - 1);

  out_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             pair_full;
  logic             phase_i;     // 0: next bit is Q, 1: next bit is I
  logic             q_buf, i_buf;
  logic             accept, stored_bit;
  logic             load, undr;

  assign bit_ready_o = !pair_full;
  assign accept      = bit_valid_i & bit_ready_o;

`ifdef IQ_SPLIT_SCRAMBLE_EN
  qpsk_scrambler u_scr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .bit_i (bit_i),
    .bit_o (stored_bit)
  );
`else
  assign stored_bit = bit_i;
`endif

  // Collect side; a load never coincides with an I-phase accept since ready
  // is low whenever a pair is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_i   <= 1'b0;
      q_buf     <= 1'b0;
      i_buf     <= 1'b0;
      pair_full <= 1'b0;
    end else begin
      if (accept) begin
        phase_i <= ~phase_i;
        if (!phase_i) q_buf <= stored_bit;
        else          i_buf <= stored_bit;
      end
      if (load)                  pair_full <= 1'b0;
      else if (accept & phase_i) pair_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    undr      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pair_full) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == CNT_LAST) begin
          if (pair_full) begin
            load = 1'b1;
          end else begin
            undr      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Symbol outputs only move at a load or when falling back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      sym_I_o      <= 1'b0;
      sym_Q_o      <= 1'b0;
      sym_valid_o  <= 1'b0;
      sym_strobe_o <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      sym_strobe_o <= load;
      underrun_o   <= undr;
      if (load) begin
        cnt         <= '0;
        sym_I_o     <= i_buf;
        sym_Q_o     <= q_buf;
        sym_valid_o <= 1'b1;
      end else if (undr) begin
        cnt         <= '0;
        sym_I_o     <= 1'b0;
        sym_Q_o     <= 1'b0;
        sym_valid_o <= 1'b0;
      end else if (state == ST_RUN) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
